ram_bist_ctrl: RTL and testbench

- Built-in self-test initiator for the 16-bit word RAM family (RAM8 up to RAM16K). It is the requester side of the RAM port.
- On `start` it drives the RAM's read strobe, write strobe, address and write data (r/w/addr/D) through a four-pass march:
  - write pattern, then read and compare;
  - write inverted pattern, then read and compare.
- It reports pass/fail, the first failing address and a saturating error count.
- It sits between the test/debug controller and one RAM instance, muxed ahead of the functional port.

---
 rtl/bist_pkg.sv | 30 +++
 rtl/ram_bist_cmp.sv | 51 +++++
 rtl/ram_bist_ctrl.sv | 153 +++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and helpers for the RAM march BIST.
// State set, pass indices and the test pattern.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR0,
    RD1,
    WR2,
    RD3,
    DONE
  } state_e;

  // Pass reported alongside the first miscompare.
  localparam logic PASS_RD1 = 1'b0;
  localparam logic PASS_RD3 = 1'b1;

  // Seed XOR address, optionally inverted.
  // Callers truncate to their data width.
  function automatic logic [31:0] pat(
    input logic [31:0] seed,
    input logic [31:0] a,
    input logic        inv
  );
    logic [31:0] p;
    p = seed ^ a;
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data checker for the march BIST.
// Sticky fail, first-fail capture, saturating count.
module ram_bist_cmp #(
  parameter int AW = 7,
  parameter int DW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          smp_i,
  input  logic          pass_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] exp_i,
  input  logic [DW-1:0] act_i,
  output logic          fail_o,
  output logic [AW-1:0] fail_addr_o,
  output logic          fail_pass_o,
  output logic [CW-1:0] err_count_o
);

  logic          fail_q;
  logic [AW-1:0] faddr_q;
  logic          fpass_q;
  logic [CW-1:0] err_q;

  // Only the first miscompare of a test is captured.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      fail_q  <= 1'b0;
      faddr_q <= '0;
      fpass_q <= 1'b0;
      err_q   <= '0;
    end else if (smp_i && (act_i != exp_i)) begin
      if (err_q != '1) begin
        err_q <= err_q + CW'(1);
      end
      if (!fail_q) begin
        fail_q  <= 1'b1;
        faddr_q <= addr_i;
        fpass_q <= pass_i;
      end
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = faddr_q;
  assign fail_pass_o = fpass_q;
  assign err_count_o = err_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// March BIST initiator for the 16-bit word RAMs.
// Write P, read P, write ~P, read ~P.
import bist_pkg::*;

module ram_bist_ctrl #(
  parameter int          AW       = 7,
  parameter int          DW       = 16,
  parameter int          READ_LAT = 1,
  parameter logic [15:0] SEED     = 16'hA5A5,
  parameter int          CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic          fail_pass,
  output logic [CW-1:0] err_count,
  output logic          ram_r,
  output logic          ram_w,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_o
);

  localparam logic [AW-1:0] AMAX = '1;
  localparam logic [2:0]    LMAX = 3'(READ_LAT);

  state_e        st_q;
  logic [AW-1:0] addr_q;
  logic [2:0]    lat_q;
  logic          busy_q;
  logic          done_q;
  logic          r_q;
  logic          w_q;
  logic [DW-1:0] d_q;

  logic [AW-1:0] addr_inc;
  logic          last;
  logic          in_rd;
  logic          smp;
  logic          clr;
  logic          pidx;
  logic [DW-1:0] exp_dat;
  logic [DW-1:0] nxt_dat;

  assign addr_inc = addr_q + AW'(1);
  assign last     = (addr_q == AMAX);
  assign in_rd    = (st_q == RD1) || (st_q == RD3);
  assign smp      = in_rd && (lat_q == LMAX);
  assign clr      = start &&
                    ((st_q == IDLE) || (st_q == DONE));
  assign pidx     = (st_q == RD3) ? PASS_RD3 : PASS_RD1;

  assign exp_dat = DW'(pat(32'(SEED), 32'(addr_q),
                           st_q == RD3));
  assign nxt_dat = DW'(pat(32'(SEED), 32'(addr_inc),
                           st_q == WR2));

  // Sequencer; RAM strobes are set for the coming cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      addr_q <= '0;
      lat_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      r_q    <= 1'b0;
      w_q    <= 1'b0;
      d_q    <= '0;
    end else begin
      unique case (st_q)
        IDLE, DONE: begin
          if (start) begin
            st_q   <= WR0;
            addr_q <= '0;
            lat_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            w_q    <= 1'b1;
            r_q    <= 1'b0;
            d_q    <= DW'(pat(32'(SEED), 32'd0, 1'b0));
          end
        end
        WR0, WR2: begin
          if (last) begin
            st_q   <= (st_q == WR0) ? RD1 : RD3;
            addr_q <= '0;
            lat_q  <= '0;
            w_q    <= 1'b0;
            r_q    <= 1'b1;
            d_q    <= '0;
          end else begin
            addr_q <= addr_inc;
            d_q    <= nxt_dat;
          end
        end
        RD1, RD3: begin
          if (lat_q != LMAX) begin
            lat_q <= lat_q + 3'd1;
          end else if (!last) begin
            addr_q <= addr_inc;
            lat_q  <= '0;
          end else if (st_q == RD1) begin
            st_q   <= WR2;
            addr_q <= '0;
            lat_q  <= '0;
            r_q    <= 1'b0;
            w_q    <= 1'b1;
            d_q    <= DW'(pat(32'(SEED), 32'd0, 1'b1));
          end else begin
            st_q   <= DONE;
            addr_q <= '0;
            lat_q  <= '0;
            r_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  ram_bist_cmp #(
    .AW(AW),
    .DW(DW),
    .CW(CW)
  ) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .smp_i      (smp),
    .pass_i     (pidx),
    .addr_i     (addr_q),
    .exp_i      (exp_dat),
    .act_i      (ram_o),
    .fail_o     (fail),
    .fail_addr_o(fail_addr),
    .fail_pass_o(fail_pass),
    .err_count_o(err_count)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign ram_r    = r_q;
  assign ram_w    = w_q;
  assign ram_addr = addr_q;
  assign ram_d    = d_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl at read latencies 1, 0 and 3.
// RAM models with injectable faults; expected results from a march model.
module tb_ram_bist_ctrl;

  localparam int AW = 7;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start_v [3];
  logic          busy_v  [3];
  logic          done_v  [3];
  logic          fail_v  [3];
  logic          fp_v    [3];
  logic          r_v     [3];
  logic          w_v     [3];
  logic [AW-1:0] fa_v    [3];
  logic [AW-1:0] ad_v    [3];
  logic [DW-1:0] d_v     [3];
  logic [DW-1:0] o_v     [3];
  logic [CW-1:0] ec_v    [3];

  // 0 ideal, 1 stuck-at-0, 2 bit flip, 3 reads zero
  logic [1:0] fmode [3];
  int faddr;
  int fbit;

  int checks = 0;
  int errors = 0;
  int both_rw = 0;
  logic [15:0] wr5[$];

  function automatic logic [15:0] fault(
    input logic [1:0] m, input int fa, input int fb,
    input int a, input logic [15:0] v);
    logic [15:0] bm;
    bm = 16'(1) << fb;
    case (m)
      2'd1: return (a == fa) ? (v & ~bm) : v;
      2'd2: return (a == fa) ? (v ^ bm) : v;
      2'd3: return 16'h0000;
      default: return v;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    logic [15:0] mem  [N];
    logic [15:0] pipe [4];

    ram_bist_ctrl #(
      .AW(AW), .DW(DW), .READ_LAT(L),
      .SEED(16'hA5A5), .CW(CW)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start_v[g]),
      .busy(busy_v[g]), .done(done_v[g]),
      .fail(fail_v[g]), .fail_addr(fa_v[g]),
      .fail_pass(fp_v[g]), .err_count(ec_v[g]),
      .ram_r(r_v[g]), .ram_w(w_v[g]),
      .ram_addr(ad_v[g]), .ram_d(d_v[g]),
      .ram_o(o_v[g])
    );

    always @(posedge clk) begin
      if (w_v[g]) mem[ad_v[g]] <= d_v[g];
      pipe[0] <= fault(fmode[g], faddr, fbit,
                       int'(ad_v[g]), mem[ad_v[g]]);
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    assign o_v[g] = (L == 0)
      ? fault(fmode[g], faddr, fbit,
              int'(ad_v[g]), mem[ad_v[g]])
      : pipe[(L == 0) ? 0 : L-1];
  end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++)
      if (r_v[g] && w_v[g]) both_rw++;
    if (w_v[0] && ad_v[0] == 7'd5) wr5.push_back(d_v[0]);
  end

  // March reference: what each read pass sees from the faulty RAM.
  task automatic ref_model(input logic [1:0] m,
    input int fa, input int fb,
    output logic f, output int a0,
    output logic p0, output int cnt);
    logic [15:0] e;
    f = 1'b0; a0 = 0; p0 = 1'b0; cnt = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < N; a++) begin
        e = 16'hA5A5 ^ 16'(a);
        if (p == 1) e = ~e;
        if (fault(m, fa, fb, a, e) !== e) begin
          if (!f) begin
            f = 1'b1; a0 = a; p0 = p[0];
          end
          if (cnt < 255) cnt++;
        end
      end
    end
  endtask

  task automatic run(input int g, input bit poke,
                     output int cyc);
    @(negedge clk);
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
    cyc = 0;
    while (busy_v[g] && cyc < 5000) begin
      cyc++;
      start_v[g] = poke && (cyc == 10 || cyc == 200);
      @(negedge clk);
    end
    start_v[g] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({busy_v[g], done_v[g], fail_v[g], fp_v[g],
           r_v[g], w_v[g], fa_v[g], ad_v[g],
           d_v[g], ec_v[g]} !== '0) begin
        errors++;
        $display("FAIL reset_outs dut%0d busy=%b done=%b r=%b w=%b addr=%0d d=%h ec=%0d need all 0",
                 g, busy_v[g], done_v[g], r_v[g], w_v[g],
                 ad_v[g], d_v[g], ec_v[g]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_ideal();
    int cyc;
    fmode[0] = 2'd0;
    wr5.delete();
    run(0, 1'b0, cyc);
    checks++;
    if (cyc !== 768) begin
      errors++;
      $display("FAIL ideal_busy got %0d need 768", cyc);
    end
    checks++;
    if ({done_v[0], fail_v[0], ec_v[0]} !== {1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL ideal_res done=%b fail=%b ec=%0d need 1 0 0",
               done_v[0], fail_v[0], ec_v[0]);
    end
    checks++;
    if (wr5.size() != 2) begin
      errors++;
      $display("FAIL wr5_count got %0d need 2", wr5.size());
    end else begin
      checks++;
      if (wr5[0] !== 16'hA5A0 || wr5[1] !== 16'h5A5F) begin
        errors++;
        $display("FAIL wr5_data got %h %h need a5a0 5a5f",
                 wr5[0], wr5[1]);
      end
    end
  endtask

  task automatic test_fault(input int g, input logic [1:0] m,
    input int fa, input int fb, input string tag);
    int cyc, a0, cnt, lat;
    logic f, p0;
    lat = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    fmode[g] = m; faddr = fa; fbit = fb;
    ref_model(m, fa, fb, f, a0, p0, cnt);
    run(g, 1'b0, cyc);
    checks++;
    if (cyc !== 2 * N * (lat + 2)) begin
      errors++;
      $display("FAIL %s_busy got %0d need %0d",
               tag, cyc, 2 * N * (lat + 2));
    end
    checks++;
    if (fail_v[g] !== f || fp_v[g] !== p0 ||
        int'(fa_v[g]) != a0 || int'(ec_v[g]) != cnt) begin
      errors++;
      $display("FAIL %s got fail=%b addr=%0d pass=%b ec=%0d need %b %0d %b %0d",
               tag, fail_v[g], fa_v[g], fp_v[g], ec_v[g],
               f, a0, p0, cnt);
    end
    fmode[g] = 2'd0;
  endtask

  task automatic test_faults();
    test_fault(0, 2'd1, 45, 3, "stuck45");
    test_fault(0, 2'd2, 45, 3, "flip45");
    checks++;
    if (ec_v[0] !== 8'd2 || fp_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL flip45_fixed ec=%0d pass=%b need 2 0",
               ec_v[0], fp_v[0]);
    end
    test_fault(0, 2'd3, 0, 0, "zeros");
    checks++;
    if (ec_v[0] !== 8'd255 || fa_v[0] !== 7'd0) begin
      errors++;
      $display("FAIL zeros_sat ec=%0d addr=%0d need 255 0",
               ec_v[0], fa_v[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      test_fault(0, 2'($urandom_range(1, 2)),
                 int'($urandom_range(0, N - 1)),
                 int'($urandom_range(0, 15)), "rand");
  endtask

  task automatic test_abort();
    int n, cyc;
    fmode[0] = 2'd0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (!r_v[0] && n < 400) begin
      n++;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (r_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_rd1 r=%b need 1", r_v[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy_v[0], done_v[0], fail_v[0], fp_v[0],
         r_v[0], w_v[0], fa_v[0], ad_v[0],
         d_v[0], ec_v[0]} !== '0) begin
      errors++;
      $display("FAIL abort_outs busy=%b r=%b w=%b addr=%0d d=%h need all 0",
               busy_v[0], r_v[0], w_v[0], ad_v[0], d_v[0]);
    end
    run(0, 1'b0, cyc);
    checks++;
    if (cyc !== 768 || done_v[0] !== 1'b1 ||
        fail_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_rerun busy=%0d done=%b fail=%b need 768 1 0",
               cyc, done_v[0], fail_v[0]);
    end
  endtask

  task automatic test_ignore();
    int cyc;
    run(0, 1'b1, cyc);
    checks++;
    if (cyc !== 768 || done_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy got %0d done=%b need 768 1",
               cyc, done_v[0]);
    end
    run(0, 1'b0, cyc);
    checks++;
    if (cyc !== 768 || done_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL restart_done got %0d done=%b need 768 1",
               cyc, done_v[0]);
    end
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    checks++;
    if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL restart_clr done=%b busy=%b need 0 1",
               done_v[0], busy_v[0]);
    end
    cyc = 0;
    while (busy_v[0] && cyc < 5000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_latency();
    test_fault(1, 2'd0, 0, 0, "lat0");
    test_fault(2, 2'd0, 0, 0, "lat3");
    test_fault(1, 2'd2, int'($urandom_range(0, N - 1)),
               int'($urandom_range(0, 15)), "lat0_flip");
    test_fault(2, 2'd1, int'($urandom_range(0, N - 1)),
               int'($urandom_range(0, 15)), "lat3_stuck");
  endtask

  task automatic test_rw_excl();
    checks++;
    if (both_rw != 0) begin
      errors++;
      $display("FAIL rw_excl got %0d overlaps need 0", both_rw);
    end
  endtask

  initial begin
    rst = 1'b1;
    faddr = 0;
    fbit = 0;
    for (int g = 0; g < 3; g++) begin
      start_v[g] = 1'b0;
      fmode[g] = 2'd0;
    end
    test_reset();
    test_ideal();
    test_faults();
    test_random();
    test_abort();
    test_ignore();
    test_latency();
    test_rw_excl();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
